// File: rtl/decoder_3x8_gates.sv
// Gate-level 3-to-8 one-hot decoder with optional output polarity inversion
// and an optional asynchronously reset output register.
module decoder_3x8_gates #(
  parameter bit REGISTERED = 1'b0,
  parameter bit ACTIVE_LOW = 1'b0
) (
  output logic [7:0] S,
  input  logic       a,
  input  logic       b,
  input  logic       z,
  input  logic       clk,
  input  logic       rst
);

  // "No line selected" in whichever polarity the outputs use.
  localparam logic [7:0] RST_VAL = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic       w_z_n;
  logic       w_a_n;
  logic       w_b_n;
  logic [7:0] w_minterm;
  logic [7:0] w_dec;
  logic [7:0] r_s;

  not u_inv_z (w_z_n, z);
  not u_inv_a (w_a_n, a);
  not u_inv_b (w_b_n, b);

  // One 3-input AND per minterm; each literal is the true or complemented
  // select bit chosen by the bit pattern of the minterm index.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_minterm
      localparam logic [2:0] SEL = 3'(gi);
      logic w_lit_z;
      logic w_lit_a;
      logic w_lit_b;
      assign w_lit_z = SEL[2] ? z : w_z_n;
      assign w_lit_a = SEL[1] ? a : w_a_n;
      assign w_lit_b = SEL[0] ? b : w_b_n;
      and u_and (w_minterm[gi], w_lit_z, w_lit_a, w_lit_b);
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_out_pol
      if (ACTIVE_LOW) begin : g_inv
        not u_inv_out (w_dec[gi], w_minterm[gi]);
      end else begin : g_buf
        assign w_dec[gi] = w_minterm[gi];
      end
    end
  endgenerate

  // Register is always described so clk/rst stay referenced; it is trimmed
  // away when the combinational path is selected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s <= RST_VAL;
    end else begin
      r_s <= w_dec;
    end
  end

  assign S = REGISTERED ? r_s : w_dec;

endmodule

// File: tb/tb_decoder_3x8_gates.sv
// Self-checking bench for decoder_3x8_gates: all four parameter combinations
// share one set of inputs and are compared against an arithmetic model.
module tb_decoder_3x8_gates;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       z;
  logic [7:0] s_c0;
  logic [7:0] s_c1;
  logic [7:0] s_r0;
  logic [7:0] s_r1;

  int n_assert;
  int n_fail;
  int cur_sel;
  int model_sel;

  decoder_3x8_gates #(.REGISTERED(1'b0), .ACTIVE_LOW(1'b0)) u_c0 (
    .S(s_c0), .a(a), .b(b), .z(z), .clk(clk), .rst(rst));
  decoder_3x8_gates #(.REGISTERED(1'b0), .ACTIVE_LOW(1'b1)) u_c1 (
    .S(s_c1), .a(a), .b(b), .z(z), .clk(clk), .rst(rst));
  decoder_3x8_gates #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b0)) u_r0 (
    .S(s_r0), .a(a), .b(b), .z(z), .clk(clk), .rst(rst));
  decoder_3x8_gates #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b1)) u_r1 (
    .S(s_r1), .a(a), .b(b), .z(z), .clk(clk), .rst(rst));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_word(input int sel, input bit low);
    logic [7:0] w;
    w = 8'(1 << sel);
    return low ? ~w : w;
  endfunction

  // sel < 0 stands for "held in reset / nothing captured yet".
  function automatic logic [7:0] exp_reg(input int sel, input bit low);
    if (sel < 0) return low ? 8'hFF : 8'h00;
    return exp_word(sel, low);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel);
    logic [2:0] v;
    v = 3'(sel);
    z = v[2];
    a = v[1];
    b = v[0];
    cur_sel = sel;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_sel = rst ? -1 : cur_sel;
    #1;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    model_sel = -1;
    rst       = 1'b1;
    drive(0);

    #1;
    chk("reset_r0_no_clock", s_r0, 8'h00);
    chk("reset_r1_no_clock", s_r1, 8'hFF);

    // Combinational sweeps, 10-unit steps; registered copies held in reset.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(i);
      #1;
      chk($sformatf("sweep_hi_sel%0d", i), s_c0, exp_word(i, 1'b0));
      chk($sformatf("sweep_lo_sel%0d", i), s_c1, exp_word(i, 1'b1));
      chk($sformatf("sweep_r0_in_reset_sel%0d", i), s_r0, 8'h00);
      $display("sweep sel=%0d S_hi=%h S_lo=%h", i, s_c0, s_c1);
    end

    @(negedge clk);
    drive(5);
    #1;
    chk("directed_zab_101", s_c0, 8'b0010_0000);
    drive(2);
    #1;
    chk("directed_zab_010", s_c0, 8'b0000_0100);

    // Release reset with sel=3: output waits for the first rising edge.
    @(negedge clk);
    rst = 1'b0;
    drive(3);
    #1;
    chk("rel_before_edge_r0", s_r0, 8'h00);
    chk("rel_before_edge_r1", s_r1, 8'hFF);
    clk_edge();
    chk("first_edge_r0", s_r0, 8'h08);
    chk("first_edge_r1", s_r1, 8'hF7);
    @(negedge clk);
    drive(6);
    #1;
    chk("lag_hold_r0", s_r0, 8'h08);
    clk_edge();
    chk("lag_load_r0", s_r0, 8'h40);

    // Randomized traffic against the model for all four instances.
    for (int i = 0; i < 40; i++) begin
      int s;
      @(negedge clk);
      s = int'($urandom_range(0, 7));
      chk("rand_r0_hold", s_r0, exp_reg(model_sel, 1'b0));
      drive(s);
      #1;
      chk("rand_c0", s_c0, exp_word(s, 1'b0));
      chk("rand_c1", s_c1, exp_word(s, 1'b1));
      chk("rand_c0_popcount", 8'($countones(s_c0)), 8'd1);
      chk("rand_c0_selbit", {7'd0, s_c0[s]}, 8'd1);
      chk("rand_c1_zerocount", 8'($countones(~s_c1)), 8'd1);
      clk_edge();
      chk("rand_r0", s_r0, exp_reg(model_sel, 1'b0));
      chk("rand_r1", s_r1, exp_reg(model_sel, 1'b1));
      chk("rand_r0_popcount", 8'($countones(s_r0)), 8'd1);
      chk("rand_r0_selbit", {7'd0, s_r0[s]}, 8'd1);
      $display("rand sel=%0d S_c0=%h S_c1=%h S_r0=%h S_r1=%h", s, s_c0, s_c1, s_r0, s_r1);
    end

    // Reset pulse between edges while S=80.
    @(negedge clk);
    drive(7);
    clk_edge();
    chk("pre_pulse_r0", s_r0, 8'h80);
    #2;
    rst = 1'b1;
    model_sel = -1;
    #1;
    chk("async_clear_r0", s_r0, 8'h00);
    chk("async_clear_r1", s_r1, 8'hFF);
    drive(2);
    clk_edge();
    chk("edge_in_reset_r0", s_r0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_release_r0", s_r0, 8'h00);
    clk_edge();
    chk("reload_r0", s_r0, 8'h04);
    chk("reload_r1", s_r1, 8'hFB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
